// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit for the EX stage, writing HI/LO.
// One shift-add or restoring shift-subtract step per cycle; busy_o stalls the front end.
module ex_muldiv_unit #(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] OP_MULT  = 4'b1000,
    parameter logic [3:0] OP_MULTU = 4'b1001,
    parameter logic [3:0] OP_DIV   = 4'b1010,
    parameter logic [3:0] OP_DIVU  = 4'b1011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [3:0]       ALUOp_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, m_q, a_raw_q, hi_q, lo_q;
    logic             div_q, neg_q, rneg_q;

    logic             is_md, accept, op_signed, op_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_sum, rem_sh;
    logic [WIDTH-1:0] sub_diff, step_hi, step_lo, q_fix, r_fix, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic             sub_ok, div0;

    assign is_md     = valid_i && (ALUOp_i == OP_MULT || ALUOp_i == OP_MULTU ||
                                   ALUOp_i == OP_DIV  || ALUOp_i == OP_DIVU);
    assign op_signed = ALUOp_i == OP_MULT || ALUOp_i == OP_DIV;
    assign op_div    = ALUOp_i == OP_DIV  || ALUOp_i == OP_DIVU;
    assign accept    = is_md && !flush_i && (state_q == S_IDLE || state_q == S_DONE);
    assign a_neg     = op_signed && a_i[WIDTH-1];
    assign b_neg     = op_signed && b_i[WIDTH-1];
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;

    // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
    // divide shifts the dividend out of acc_lo into the remainder while quotient bits enter.
    assign add_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);
    assign rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign sub_ok   = rem_sh >= {1'b0, m_q};
    assign sub_diff = rem_sh[WIDTH-1:0] - m_q;
    assign step_hi  = div_q ? (sub_ok ? sub_diff : rem_sh[WIDTH-1:0]) : add_sum[WIDTH:1];
    assign step_lo  = div_q ? {acc_lo_q[WIDTH-2:0], sub_ok} : {add_sum[0], acc_lo_q[WIDTH-1:1]};

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign q_fix    = neg_q ? -acc_lo_q : acc_lo_q;
    assign r_fix    = rneg_q ? -acc_hi_q : acc_hi_q;
    assign div0     = m_q == '0;
    assign res_hi   = div_q ? (div0 ? a_raw_q : r_fix) : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = div_q ? (div0 ? '1 : q_fix) : prod_fix[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_RUN : S_IDLE;
            S_RUN:   state_d = flush_i ? S_IDLE : (cnt_q == CW'(WIDTH - 1) ? S_FIX : S_RUN);
            S_FIX:   state_d = flush_i ? S_IDLE : S_DONE;
            default: state_d = accept ? S_RUN : S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            m_q      <= '0;
            a_raw_q  <= '0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (accept) begin
                cnt_q    <= '0;
                acc_hi_q <= '0;
                acc_lo_q <= op_div ? a_mag : b_mag;
                m_q      <= op_div ? b_mag : a_mag;
                a_raw_q  <= a_i;
                div_q    <= op_div;
                neg_q    <= a_neg ^ b_neg;
                rneg_q   <= a_neg;
            end else if (state_q == S_RUN) begin
                cnt_q    <= cnt_q + CW'(1);
                acc_hi_q <= step_hi;
                acc_lo_q <= step_lo;
            end
            if (state_q == S_FIX && !flush_i) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    assign busy_o = state_q == S_RUN || state_q == S_FIX;
    assign done_o = state_q == S_DONE;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and random checks of ex_muldiv_unit against a scoreboard.
// Expected HI/LO pairs are queued at issue and popped whenever done_o pulses.
module tb_ex_muldiv_unit;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;

    logic        clk = 1'b0;
    logic        rst_n, valid_i, flush_i;
    logic [3:0]  ALUOp_i;
    logic [31:0] a_i, b_i, hi_o, lo_o;
    logic        busy_o, done_o;

    int n_cmp = 0;
    int n_fail = 0;
    int n_done = 0;
    logic [63:0] sbq[$];

    ex_muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ALUOp_i(ALUOp_i),
        .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
        .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic signed [63:0] sp;
        sa = a;
        sb = b;
        if (op == OP_MULTU) return {32'b0, a} * {32'b0, b};
        if (op == OP_MULT) begin
            sp = 64'(sa) * 64'(sb);
            return sp;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == OP_DIVU) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done_o) begin
            n_done++;
            chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) chk("hilo", {hi_o, lo_o}, sbq.pop_front());
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_i = 1'b1;
        ALUOp_i = op;
        a_i = a;
        b_i = b;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        ALUOp_i = 4'($urandom);
        a_i = $urandom;
        b_i = $urandom;
    endtask

    task automatic wait_done(input string tag, output int cyc, output int busy_cyc);
        cyc = 0;
        busy_cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy_o) busy_cyc++;
        end while (!done_o && cyc < 80);
        chk({tag, "_done_seen"}, 64'(done_o), 64'd1);
    endtask

    initial begin
        int cyc, bc, d0;
        logic [3:0] op;
        logic [31:0] a, b;
        rst_n = 1'b0;
        valid_i = 1'b0;
        flush_i = 1'b0;
        ALUOp_i = 4'd0;
        a_i = '0;
        b_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {30'b0, busy_o, done_o, hi_o, lo_o}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        sbq.push_back({32'hFFFF_FFFE, 32'h0000_0001});
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", cyc, bc);
        chk("multu_busy_cycles", 64'(bc), 64'd33);
        chk("multu_latency", 64'(cyc), 64'd34);

        sbq.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult_neg", cyc, bc);
        sbq.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", cyc, bc);

        sbq.push_back({32'h0000_0064, 32'hFFFF_FFFF});
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_done("divu_zero", cyc, bc);
        sbq.push_back({32'h0, 32'h8000_0000});
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", cyc, bc);
        @(negedge clk);

        d0 = n_done;
        issue(OP_MULTU, 32'd5, 32'd6);
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_busy_drop", 64'(busy_o), 64'd0);
        chk("flush_hold", {hi_o, lo_o}, {32'h0, 32'h8000_0000});
        repeat (40) @(negedge clk);
        chk("flush_no_done", 64'(n_done - d0), 64'd0);

        flush_i = 1'b1;
        issue(OP_MULT, 32'd9, 32'd9);
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_blocks_accept", 64'(busy_o), 64'd0);
        issue(4'b0010, 32'd9, 32'd9);
        @(negedge clk);
        chk("non_md_ignored", 64'(busy_o), 64'd0);
        valid_i = 1'b0;
        ALUOp_i = OP_MULT;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("invalid_ignored", 64'(busy_o), 64'd0);

        sbq.push_back({32'd2, 32'd14});
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done("divu_b2b_first", cyc, bc);
        sbq.push_back({32'd0, 32'd12});
        issue(OP_MULTU, 32'd3, 32'd4);
        @(negedge clk);
        chk("b2b_no_gap", 64'(busy_o), 64'd1);
        wait_done("multu_b2b_second", cyc, bc);
        chk("b2b_latency", 64'(cyc + 1), 64'd34);

        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {30'b0, busy_o, done_o, hi_o, lo_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 64'(busy_o), 64'd0);
        sbq.push_back({32'd0, 32'd6});
        issue(OP_MULT, 32'd2, 32'd3);
        wait_done("mult_after_reset", cyc, bc);

        for (int i = 0; i < 8; i++) begin
            op = 4'b1000 | 4'($urandom_range(0, 3));
            a = (i == 4) ? 32'h8000_0000 : $urandom;
            b = (i == 2) ? 32'd0 : (i == 3) ? 32'($urandom_range(1, 20)) : $urandom;
            sbq.push_back(model(op, a, b));
            issue(op, a, b);
            wait_done("random_op", cyc, bc);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage, downstream of the ID/EX control pipeline register. It consumes the registered 4-bit ALUOp and the EX-stage operands, and runs MULT/MULTU/DIV/DIVU over WIDTH+2 cycles. Results go to architectural HI/LO registers. While busy it stalls the front of the pipeline.

Parameters:
WIDTH, 32, operand width; also the iteration count
OP_MULT, 4'b1000, ALUOp code for signed multiply
OP_MULTU, 4'b1001, ALUOp code for unsigned multiply
OP_DIV, 4'b1010, ALUOp code for signed divide
OP_DIVU, 4'b1011, ALUOp code for unsigned divide

Ports:
clk  input  1  pipeline clock; all state changes on its rising edge
rst_n  input  1  asynchronous active-low reset
valid_i  input  1  EX stage holds a valid instruction this cycle
ALUOp_i  input  4  ALUOp from the ID/EX control register
a_i  input  WIDTH  rs operand; multiplicand or dividend
b_i  input  WIDTH  rt operand; multiplier or divisor
flush_i  input  1  kill the in-flight operation (branch/jump flush)
busy_o  output  1  operation in progress; upstream stages hold while high
done_o  output  1  one-cycle pulse; HI/LO were updated this cycle
hi_o  output  WIDTH  HI register: product upper half or remainder
lo_o  output  WIDTH  LO register: product lower half or quotient

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy_o=0, done_o=0, hi_o=0, lo_o=0, iteration counter=0, all datapath registers=0. Reset asserted mid-operation aborts the operation immediately.
- is_md = valid_i && ALUOp_i is one of the four OP_* codes. Any other ALUOp_i is ignored.
- States:
  - IDLE: if is_md && !flush_i, accept. Latch operation type and operand magnitudes (absolute values for signed ops; raw values for unsigned). Latch result sign flags. Counter=0. Go to RUN.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter increments. After step WIDTH-1, go to FIX.
  - FIX: apply sign correction and divide-by-zero override. Go to DONE.
  - DONE: write hi_o/lo_o and pulse done_o=1. If is_md && !flush_i, accept a new operation and go to RUN (back-to-back). Otherwise go to IDLE.
- busy_o = 1 in RUN and FIX, 0 in IDLE and DONE.
- Latency: accept at edge N; done_o high and HI/LO valid in cycle N+WIDTH+2 (34 cycles for WIDTH=32).
- Multiply: produce the 2*WIDTH-bit product. Signed result is negated when the operand signs differ. hi_o takes the upper half, lo_o the lower half.
- Divide: quotient to lo_o, remainder to hi_o.
  - Signed quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - Magnitudes are WIDTH-bit unsigned, so |0x80000000| = 0x80000000.
- Divide by zero (b_i==0, DIV or DIVU): lo_o=all ones, hi_o=a_i as latched at accept.
- Signed overflow (0x80000000 / -1): lo_o=0x80000000, hi_o=0. This falls out of the magnitude arithmetic with no special case.
- flush_i: in RUN or FIX, return to IDLE next edge. hi_o/lo_o keep their previous values, done_o is not asserted, busy_o drops next cycle. In IDLE or DONE, flush_i blocks acceptance. A DONE-cycle HI/LO write still completes.
- Simultaneous flush_i and is_md: flush wins and nothing is accepted.
- ALUOp_i, a_i and b_i may change after accept without affecting the operation.
- hi_o and lo_o change only in DONE, or on reset.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy_o high for 33 cycles; done_o at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULTU 5*6, then assert flush_i in RUN cycle 10 -> busy_o=0 next cycle, no done_o pulse, hi/lo still hold the previous result.
- DIVU 100/7 followed by MULTU 3*4 presented in the DONE cycle -> first done: lo=14, hi=2. Second accepted with no idle gap; its done comes 34 cycles later: hi=0, lo=12.
- Pull rst_n low at RUN cycle 5 of a DIV -> busy_o, done_o, hi_o and lo_o go to 0 immediately without a clock edge. After release, state is IDLE and a new MULT 2*3 gives lo=6.
